// File: rtl/punto_fijo_pkg.sv
// punto_fijo_pkg: shared Q-format helpers (state codes, symmetric limits, format check)
package punto_fijo_pkg;
  typedef logic [1:0] estado_t;
  localparam estado_t IDLE = 2'd0, MULT = 2'd1, AJUSTE = 2'd2, LISTO = 2'd3;
  function automatic int max_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int lim_neg(input int w);
    return (1 << (w - 1)) + 1;
  endfunction
  function automatic bit formato_ok(input int w, input int s, input int m, input int p);
    return (w == s + m + p) && (s == 1) && (p >= 1);
  endfunction
endpackage

// File: rtl/saturador_punto_fijo.sv
// saturador_punto_fijo: rescales a 2W-bit magnitude to Q format with symmetric clamp
// Optional REDONDEO_EN: round half away from zero instead of truncating
module saturador_punto_fijo
  import punto_fijo_pkg::*;
#(
  parameter int Width     = 4,
  parameter int Presicion = 2
) (
  input  logic [2*Width-1:0] mag,
  input  logic               sign,
  output logic [Width-1:0]   y,
  output logic               sat
);
  localparam int N = 2 * Width + 1;
`ifdef REDONDEO_EN
  localparam logic [N-1:0] RND = N'(1) << (Presicion - 1);
`else
  localparam logic [N-1:0] RND = '0;
`endif
  localparam logic [Width-1:0] POS = Width'(max_pos(Width));
  localparam logic [Width-1:0] NEG = Width'(lim_neg(Width));
  logic [N-1:0] m;
  always_comb begin
    m   = ({1'b0, mag} + RND) >> Presicion;
    sat = m > N'(POS);
    y   = sat ? (sign ? NEG : POS) : (sign ? -m[Width-1:0] : m[Width-1:0]);
  end
endmodule

// File: rtl/multiplicador_secuencial.sv
// multiplicador_secuencial: signed Q-format shift-add multiplier, one bit per clock
// Build option REDONDEO_EN selects rounding in the saturator (latency unchanged)
module multiplicador_secuencial
  import punto_fijo_pkg::*;
#(
  parameter int Width     = 4,
  parameter int Signo     = 1,
  parameter int Magnitud  = 1,
  parameter int Presicion = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic [Width-1:0] Y,
  output logic             Sat,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(Width);
  if (!formato_ok(Width, Signo, Magnitud, Presicion)) begin : g_formato
    $error("multiplicador_secuencial: invalid Q format");
  end
  estado_t              estado, estado_sig;
  logic [CW-1:0]        cnt;
  logic [2*Width-1:0]   mag_a, acc;
  logic [Width-1:0]     mag_b, y_sat;
  logic                 sign, sat_sat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= IDLE;
    else estado <= estado_sig;
  always_comb
    estado_sig = (estado == IDLE)   ? (start ? MULT : IDLE) :
                 (estado == MULT)   ? ((cnt == CW'(Width - 1)) ? AJUSTE : MULT) :
                 (estado == AJUSTE) ? LISTO : IDLE;
  always_comb begin
    busy = estado != IDLE;
    done = estado == LISTO;
  end
  // mag_a is pre-shifted each cycle so bit i of mag_b adds mag_a<<i
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      sign  <= 1'b0;
      Y     <= '0;
      Sat   <= 1'b0;
    end else if (estado == IDLE && start) begin
      cnt   <= '0;
      mag_a <= {{Width{1'b0}}, A[Width-1] ? -A : A};
      mag_b <= B[Width-1] ? -B : B;
      acc   <= '0;
      sign  <= A[Width-1] ^ B[Width-1];
    end else if (estado == MULT) begin
      acc   <= acc + (mag_b[0] ? mag_a : '0);
      mag_a <= mag_a << 1;
      mag_b <= mag_b >> 1;
      cnt   <= cnt + 1'b1;
    end else if (estado == AJUSTE) begin
      Y     <= y_sat;
      Sat   <= sat_sat;
    end
  saturador_punto_fijo #(.Width(Width), .Presicion(Presicion)) u_sat (
    .mag  (acc),
    .sign (sign),
    .y    (y_sat),
    .sat  (sat_sat)
  );
endmodule

// File: doc/multiplicador_secuencial.md
Name: multiplicador_secuencial

Overview:
Sequential signed fixed-point multiplier that sits directly upstream of the saturating adder; its product feeds the adder's A/B inputs in the datapath's multiply-accumulate chain. It uses the same Q format (sign + Magnitud integer bits + Presicion fraction bits) and the same symmetric saturation convention as the adder. Shift-add over operand magnitudes, one bit per clock, with a start/busy/done handshake.

Parameters:
Width, 4, total word width; must equal Signo+Magnitud+Presicion.
Signo, 1, sign bits; fixed at 1.
Magnitud, 1, integer bits.
Presicion, 2, fraction bits; must be ≥1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  Width  signed fixed-point multiplicand
B  input  Width  signed fixed-point multiplier
Y  output  Width  signed fixed-point product, registered, held until next result
Sat  output  1  1 = last product was saturated
busy  output  1  operation in progress
done  output  1  one-cycle pulse: Y/Sat updated

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n, asynchronous, active-low.
- Reset: state=IDLE; Y=0, Sat=0, busy=0, done=0; internal registers cleared. Asserting reset mid-operation aborts the operation immediately and discards the partial product.
- Handshake timing:
  - The edge that samples start=1 in IDLE also latches A and B, sign = A[msb]^B[msb], magA=|A|, magB=|B| (Width-bit unsigned; |-2^(W-1)| = 2^(W-1) fits).
  - busy=1 from the next cycle through the done cycle inclusive.
  - done=1 for exactly one cycle, W+2 cycles after the start-sampling edge.
  - start is ignored while busy.
  - A new start may be sampled in the cycle after done.
- States:
  - IDLE: start → MULT.
  - MULT: W cycles. Each cycle: if magB[0], acc += magA<<i (acc is 2W-bit unsigned); magB >>= 1; counter++. Counter reaches W-1 → AJUSTE.
  - AJUSTE: 1 cycle. m = acc >> Presicion. If m > 2^(W-1)-1: mag = 2^(W-1)-1, Sat=1; else mag = m, Sat=0. Y = sign ? -mag : mag. Y and Sat are registered on leaving this state.
  - LISTO: done=1 → IDLE.
- Saturation is symmetric:
  - positive limit 2^(W-1)-1;
  - negative limit -(2^(W-1)-1), i.e. 2^(W-1)+1 as a pattern;
  - the most negative code 2^(W-1) is never produced.
- Zero result is always +0. A zero product with sign=1 gives Y=0.
- Width rules: Y and Sat change only on the LISTO-entry edge. They stay stable during MULT/AJUSTE of the next operation until its own done.

Optional Feature:
REDONDEO_EN.
- Defined: in AJUSTE, m = (acc + 2^(Presicion-1)) >> Presicion. This is round-half-away-from-zero on magnitude; saturation is checked after rounding.
- Undefined: truncation of magnitude (round toward zero). Latency is identical in both builds.

Decomposition:
- Shared package (punto_fijo_pkg):
  - state encoding localparams IDLE/MULT/AJUSTE/LISTO;
  - functions for max positive 2^(W-1)-1 and symmetric negative limit;
  - format sanity check (Width == Signo+Magnitud+Presicion).
  The adder reuses the limit functions.
- One sub-module: saturador_punto_fijo, combinational. Inputs: 2W-bit magnitude, sign. Outputs: Width-bit Y, Sat. Contains shift, optional rounding and clamp. The FSM/datapath stays in the top module.

Test Plan (Width=8, Magnitud=3, Presicion=4, Q3.4):
- A=0x18 (1.5), B=0x20 (2.0), start 1 cycle → done 10 cycles after sampling edge, Y=0x30 (3.0), Sat=0; busy high cycles 1..10.
- A=0xE8 (-1.5), B=0x20 → Y=0xD0 (-3.0), Sat=0.
- A=0x40 (4.0), B=0x40 → Y=0x7F, Sat=1.
- A=0x80 (-8.0), B=0x10 (1.0) → Y=0x81, Sat=1 (symmetric limit, not 0x80).
- A=0x01, B=0x08 (0.0625×0.5) → Y=0x00 without REDONDEO_EN; Y=0x01 with REDONDEO_EN.
- Start op, pull rst_n low 3 cycles into MULT → busy/done/Y/Sat=0 asynchronously. Release, start 0x18×0x20 → Y=0x30 after 10 cycles. A start pulse during busy is ignored (no extra done).
